// File: rtl/event_msg_pkg.sv
// rtl/event_msg_pkg.sv - shared message constants, grant class type and beat builders
// Purpose: message-type codes, field positions of the 256-bit merged message,
//          the grant class enum and helpers that assemble response and event beats.
// Ports:   none (package).
// Options: EVENT_TIMESTAMP_EN (see event_pending_bank / event_msg_arbiter).
package event_msg_pkg;

   localparam int MSG_WIDTH        = 256;
   localparam int RSP_PAYLOAD_W    = 248;

   localparam logic [7:0] MSG_TYPE_AXI_RSP = 8'd0;
   localparam logic [7:0] MSG_TYPE_EVENT   = 8'd1;
   localparam logic [7:0] EVENT_UNDERFLOW  = 8'd1;

   localparam int MSG_TYPE_LSB  = 248;
   localparam int MSG_TYPE_MSB  = 255;
   localparam int EVT_TYPE_LSB  = 0;
   localparam int EVT_TYPE_MSB  = 7;
   localparam int EVT_DROPS_LSB = 8;
   localparam int EVT_DROPS_MSB = 15;
   localparam int EVT_TS_LSB    = 16;
   localparam int EVT_TS_MSB    = 47;

   typedef enum logic {
      GRANT_RSP = 1'b0,
      GRANT_EVT = 1'b1
   } grant_class_e;

   function automatic logic [MSG_WIDTH-1:0] build_rsp_msg(
      input logic [RSP_PAYLOAD_W-1:0] payload
   );
      logic [MSG_WIDTH-1:0] m;
      m = '0;
      m[MSG_TYPE_MSB:MSG_TYPE_LSB] = MSG_TYPE_AXI_RSP;
      m[RSP_PAYLOAD_W-1:0]         = payload;
      return m;
   endfunction

   function automatic logic [MSG_WIDTH-1:0] build_event_msg(
      input logic [7:0]  evt_type,
      input logic [7:0]  drops,
      input logic [31:0] ts
   );
      logic [MSG_WIDTH-1:0] m;
      m = '0;
      m[MSG_TYPE_MSB:MSG_TYPE_LSB]   = MSG_TYPE_EVENT;
      m[EVT_TYPE_MSB:EVT_TYPE_LSB]   = evt_type;
      m[EVT_DROPS_MSB:EVT_DROPS_LSB] = drops;
      m[EVT_TS_MSB:EVT_TS_LSB]       = ts;
      return m;
   endfunction

endpackage

// File: rtl/event_pending_bank.sv
// rtl/event_pending_bank.sv - pending event latches, drop counter, priority select
// Purpose: latches event strobes, counts strobes lost to an already-pending event,
//          and picks the lowest-index requester. A strobe arriving this cycle is
//          visible to the selector immediately so an idle output can emit it at once.
// Ports:   clk, reset        clock, async active-high reset
//          event_strobe      one-cycle event pulses
//          clear_sel         selected event is emitted this cycle
//          any_pending       some event is pending or strobing
//          sel_index         lowest requesting index (0-based)
//          drop_cnt          saturating drop count since last emission
//          events_dropped    sticky drop flag
//          sel_ts            timestamp of the selected event (0 unless EVENT_TIMESTAMP_EN)
// Options: EVENT_TIMESTAMP_EN builds a 32-bit cycle counter and per-event captures.
module event_pending_bank
   import event_msg_pkg::*;
#(
   parameter int NUM_EVENTS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_strobe,
   input  logic                  clear_sel,
   output logic                  any_pending,
   output logic [7:0]            sel_index,
   output logic [7:0]            drop_cnt,
   output logic                  events_dropped,
   output logic [31:0]           sel_ts
);

   logic [NUM_EVENTS-1:0] pending_q, pending_d;
   logic [NUM_EVENTS-1:0] req;
   logic [NUM_EVENTS-1:0] emit;
   logic [NUM_EVENTS-1:0] drop;
   logic [7:0]            drop_cnt_q, drop_cnt_d;
   logic                  events_dropped_q, events_dropped_d;
   logic [8:0]            drop_sum;
   logic [8:0]            drop_total;
   logic                  found;

   assign req         = pending_q | event_strobe;
   assign any_pending = |req;

   always_comb begin
      sel_index = 8'd0;
      found     = 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (req[i] && !found) begin
            sel_index = 8'(i);
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      emit      = '0;
      drop      = '0;
      pending_d = pending_q;
      drop_sum  = 9'd0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         emit[i] = clear_sel && (sel_index == 8'(i));
         // A strobe only survives emission if it is a second occurrence on top of
         // an already-latched one; a fresh strobe is consumed by its own beat.
         if (emit[i]) begin
            pending_d[i] = pending_q[i] & event_strobe[i];
         end else begin
            pending_d[i] = pending_q[i] | event_strobe[i];
         end
         drop[i]  = event_strobe[i] & pending_q[i] & ~emit[i];
         drop_sum = drop_sum + 9'(drop[i]);
      end
      drop_total       = {1'b0, (clear_sel ? 8'd0 : drop_cnt_q)} + drop_sum;
      drop_cnt_d       = (drop_total > 9'd255) ? 8'hFF : drop_total[7:0];
      events_dropped_d = events_dropped_q | (|drop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q        <= '0;
         drop_cnt_q       <= 8'd0;
         events_dropped_q <= 1'b0;
      end else begin
         pending_q        <= pending_d;
         drop_cnt_q       <= drop_cnt_d;
         events_dropped_q <= events_dropped_d;
      end
   end

   assign drop_cnt       = drop_cnt_q;
   assign events_dropped = events_dropped_q;

`ifdef EVENT_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_cnt_d;
   logic [31:0] ts_q [NUM_EVENTS];
   logic [31:0] ts_d [NUM_EVENTS];

   always_comb begin
      ts_cnt_d = ts_cnt_q + 32'd1;
      sel_ts   = 32'd0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         ts_d[i] = ts_q[i];
         // Capture whenever the strobe becomes (or stays) the live occurrence.
         if (event_strobe[i] && (!pending_q[i] || emit[i])) begin
            ts_d[i] = ts_cnt_q;
         end
         // A bypassed strobe has no capture yet; its time is the current count.
         if (sel_index == 8'(i)) begin
            sel_ts = pending_q[i] ? ts_q[i] : ts_cnt_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_cnt_q <= 32'd0;
         for (int i = 0; i < NUM_EVENTS; i++) begin
            ts_q[i] <= 32'd0;
         end
      end else begin
         ts_cnt_q <= ts_cnt_d;
         for (int i = 0; i < NUM_EVENTS; i++) begin
            ts_q[i] <= ts_d[i];
         end
      end
   end
`else
   assign sel_ts = 32'd0;
`endif

endmodule

// File: rtl/event_msg_arbiter.sv
// rtl/event_msg_arbiter.sv - merges AXI4-Lite responses and event strobes into one stream
// Purpose: alternates grants between responses and pending events on ties, and
//          drives a registered 256-bit output stage with full-throughput handshake.
// Ports:   clk, reset                       clock, async active-high reset
//          event_strobe[NUM_EVENTS]         event pulses (input i -> event type i+1)
//          events_dropped                   sticky drop flag
//          AXIS_RSP_TDATA/TVALID/TREADY     response input stream (248-bit payload)
//          AXIS_OUT_TDATA/TVALID/TREADY     merged message output stream
// Options: EVENT_TIMESTAMP_EN places a per-event cycle stamp in event beat [47:16].
module event_msg_arbiter
   import event_msg_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int NUM_EVENTS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_strobe,
   output logic                  events_dropped,
   input  logic [247:0]          AXIS_RSP_TDATA,
   input  logic                  AXIS_RSP_TVALID,
   output logic                  AXIS_RSP_TREADY,
   output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
   output logic                  AXIS_OUT_TVALID,
   input  logic                  AXIS_OUT_TREADY
);

   grant_class_e          last_grant_q, last_grant_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic                  out_free;
   logic                  grant_rsp;
   logic                  grant_evt;
   logic                  any_pending;
   logic [7:0]            sel_index;
   logic [7:0]            drop_cnt;
   logic [31:0]           sel_ts;

   event_pending_bank #(
      .NUM_EVENTS (NUM_EVENTS)
   ) u_bank (
      .clk            (clk),
      .reset          (reset),
      .event_strobe   (event_strobe),
      .clear_sel      (grant_evt),
      .any_pending    (any_pending),
      .sel_index      (sel_index),
      .drop_cnt       (drop_cnt),
      .events_dropped (events_dropped),
      .sel_ts         (sel_ts)
   );

   always_comb begin
      out_free = !out_valid_q || AXIS_OUT_TREADY;
      // On a tie the class that did not win last time goes next.
      grant_rsp = out_free && AXIS_RSP_TVALID &&
                  (!any_pending || (last_grant_q == GRANT_EVT));
      grant_evt = out_free && any_pending &&
                  (!AXIS_RSP_TVALID || (last_grant_q == GRANT_RSP));

      last_grant_d = last_grant_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      if (grant_rsp) begin
         last_grant_d = GRANT_RSP;
         out_valid_d  = 1'b1;
         out_data_d   = DATA_WIDTH'(build_rsp_msg(AXIS_RSP_TDATA));
      end else if (grant_evt) begin
         last_grant_d = GRANT_EVT;
         out_valid_d  = 1'b1;
         out_data_d   = DATA_WIDTH'(build_event_msg(sel_index + 8'd1, drop_cnt, sel_ts));
      end else if (out_free) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= GRANT_EVT;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   assign AXIS_RSP_TREADY = grant_rsp;
   assign AXIS_OUT_TVALID = out_valid_q;
   assign AXIS_OUT_TDATA  = out_data_q;

endmodule
